// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the core top level and the pipeline hazard controller.
// The master side is the core; the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              fwd_en;
    logic              id_valid;
    logic [ADDR_W-1:0] id_src1;
    logic [ADDR_W-1:0] id_src2;
    logic              id_two_src;
    logic              id_wb_en;
    logic              id_mem_r_en;
    logic [ADDR_W-1:0] id_dest;
    logic              exe_branch_taken;
    logic              mem_wait;
    logic              freeze;
    logic              flush;
    logic              pipe_hold;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output fwd_en, id_valid, id_src1, id_src2, id_two_src, id_wb_en,
               id_mem_r_en, id_dest, exe_branch_taken, mem_wait,
        input  freeze, flush, pipe_hold, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  fwd_en, id_valid, id_src1, id_src2, id_two_src, id_wb_en,
               id_mem_r_en, id_dest, exe_branch_taken, mem_wait,
        output freeze, flush, pipe_hold, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage core, driven by a registered
// scoreboard of the instructions in EXE (e0), MEM (e1) and WB (e2).
module pipeline_hazard_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic              two_src;
    } entry_t;

    typedef enum logic [1:0] {HOLD, FLUSH, STALL, ADVANCE} mode_t;

    entry_t           e0, e1, e2, id_entry;
    mode_t            mode;
    logic             hz;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    function automatic logic match(entry_t e, logic [ADDR_W-1:0] r);
        return e.valid & e.wb_en & (e.dest == r);
    endfunction

    // MEM result is younger than WB, so it wins when both write the register.
    function automatic logic [1:0] fwd_src(entry_t m, entry_t w, logic [ADDR_W-1:0] r);
        if (match(m, r)) return 2'd1;
        if (match(w, r)) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = bus.id_valid;
        id_entry.wb_en    = bus.id_wb_en;
        id_entry.mem_r_en = bus.id_mem_r_en;
        id_entry.dest     = bus.id_dest;
        id_entry.src1     = bus.id_src1;
        id_entry.src2     = bus.id_src2;
        id_entry.two_src  = bus.id_two_src;

        // WB is never a hazard: the register file writes through.
        if (bus.fwd_en)
            hz = bus.id_valid & e0.mem_r_en &
                 (match(e0, bus.id_src1) | bus.id_two_src & match(e0, bus.id_src2));
        else
            hz = bus.id_valid &
                 (match(e0, bus.id_src1) | match(e1, bus.id_src1) |
                  bus.id_two_src & (match(e0, bus.id_src2) | match(e1, bus.id_src2)));

        mode = ADVANCE;
        if (bus.mem_wait)              mode = HOLD;
        else if (bus.exe_branch_taken) mode = FLUSH;
        else if (hz)                   mode = STALL;
    end

    assign bus.freeze    = !rst && (mode == HOLD || mode == STALL);
    assign bus.flush     = !rst && (mode == FLUSH);
    assign bus.pipe_hold = !rst && (mode == HOLD);
    assign bus.fwd_sel_a = (rst || !bus.fwd_en || !e0.valid) ? 2'd0 : fwd_src(e1, e2, e0.src1);
    assign bus.fwd_sel_b = (rst || !bus.fwd_en || !e0.valid || !e0.two_src) ? 2'd0
                                                                            : fwd_src(e1, e2, e0.src2);
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0        <= '0;
            e1        <= '0;
            e2        <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (mode != HOLD) begin
            e2 <= e1;
            e1 <= e0;
            e0 <= (mode == ADVANCE) ? id_entry : '0;
            if (mode == STALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (mode == FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand-written reset and
// saturation sequence, then random traffic against an instruction-level model.
module tb_pipeline_hazard_ctrl;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(16)) bif();
    pipeline_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(2))  sif();

    assign sif.fwd_en           = bif.fwd_en;
    assign sif.id_valid         = bif.id_valid;
    assign sif.id_src1          = bif.id_src1;
    assign sif.id_src2          = bif.id_src2;
    assign sif.id_two_src       = bif.id_two_src;
    assign sif.id_wb_en         = bif.id_wb_en;
    assign sif.id_mem_r_en      = bif.id_mem_r_en;
    assign sif.id_dest          = bif.id_dest;
    assign sif.exe_branch_taken = bif.exe_branch_taken;
    assign sif.mem_wait         = bif.mem_wait;

    pipeline_hazard_ctrl #(.ADDR_W(AW), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bif));
    pipeline_hazard_ctrl #(.ADDR_W(AW), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(sif));

    typedef struct {bit v; bit wb; bit ld; bit two; int d; int s1; int s2;} ins_t;
    typedef struct {bit fwd; ins_t i; bit br; bit mw;
                    bit fz; bit fl; bit ho; int sa; int sb; int sc; int fc;} vec_t;

    ins_t stg[3];            // instruction-level view: [0] EXE, [1] MEM, [2] WB
    ins_t cur;
    bit   cur_fwd, cur_br, cur_mw;
    int   m_stall, m_flush;
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    vec_t vecs[$];

    function automatic ins_t mk(bit v, bit wb, bit ld, bit two, int d, int s1, int s2);
        ins_t r;
        r.v = v; r.wb = wb; r.ld = ld; r.two = two; r.d = d; r.s1 = s1; r.s2 = s2;
        return r;
    endfunction

    function automatic vec_t vv(bit fwd, ins_t i, bit br, bit mw, bit fz, bit fl, bit ho,
                                int sa, int sb, int sc, int fc);
        vec_t r;
        r.fwd = fwd; r.i = i; r.br = br; r.mw = mw; r.fz = fz; r.fl = fl; r.ho = ho;
        r.sa = sa; r.sb = sb; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    function automatic int sat(int x, int mx);
        return (x > mx) ? mx : x;
    endfunction

    function automatic bit writes(ins_t p, int r);
        return p.v && p.wb && (p.d == r);
    endfunction

    // Does the ID instruction have to wait this cycle?
    function automatic bit m_hz();
        bit any = 1'b0;
        if (!cur.v) return 1'b0;
        if (cur_fwd)
            return stg[0].ld && (writes(stg[0], cur.s1) || (cur.two && writes(stg[0], cur.s2)));
        for (int k = 0; k < 2; k++)
            if (writes(stg[k], cur.s1) || (cur.two && writes(stg[k], cur.s2))) any = 1'b1;
        return any;
    endfunction

    // Nearest older producer of the EXE operand: 1 = MEM, 2 = WB, 0 = register file.
    function automatic int m_sel(bit opb);
        int src;
        if (!cur_fwd || !stg[0].v || (opb && !stg[0].two)) return 0;
        src = opb ? stg[0].s2 : stg[0].s1;
        for (int k = 1; k <= 2; k++)
            if (writes(stg[k], src)) return k;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) stg[k] = mk(0, 0, 0, 0, 0, 0, 0);
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_step();
        bit h = m_hz();
        if (cur_mw) return;
        stg[2] = stg[1];
        stg[1] = stg[0];
        if (cur_br)  begin stg[0] = mk(0, 0, 0, 0, 0, 0, 0); m_flush++; end
        else if (h)  begin stg[0] = mk(0, 0, 0, 0, 0, 0, 0); m_stall++; end
        else               stg[0] = cur;
    endtask

    task automatic chk(string nm, logic [31:0] got, int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic apply(bit fwd, ins_t i, bit br, bit mw);
        cur = i; cur_fwd = fwd; cur_br = br; cur_mw = mw;
        bif.fwd_en           = fwd;
        bif.id_valid         = i.v;
        bif.id_wb_en         = i.wb;
        bif.id_mem_r_en      = i.ld;
        bif.id_two_src       = i.two;
        bif.id_dest          = i.d[AW-1:0];
        bif.id_src1          = i.s1[AW-1:0];
        bif.id_src2          = i.s2[AW-1:0];
        bif.exe_branch_taken = br;
        bif.mem_wait         = mw;
    endtask

    task automatic check_model();
        bit h = m_hz();
        chk("freeze",    bif.freeze,    int'(cur_mw || (!cur_br && h)));
        chk("flush",     bif.flush,     int'(!cur_mw && cur_br));
        chk("pipe_hold", bif.pipe_hold, int'(cur_mw));
        chk("fwd_sel_a", bif.fwd_sel_a, m_sel(1'b0));
        chk("fwd_sel_b", bif.fwd_sel_b, m_sel(1'b1));
        chk("stall_cnt", bif.stall_cnt, sat(m_stall, 65535));
        chk("flush_cnt", bif.flush_cnt, sat(m_flush, 65535));
        chk("sat_stall_cnt", sif.stall_cnt, sat(m_stall, 3));
        chk("sat_flush_cnt", sif.flush_cnt, sat(m_flush, 3));
    endtask

    task automatic cycle(bit fwd, ins_t i, bit br, bit mw);
        apply(fwd, i, br, mw);
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic run_vec(vec_t t);
        apply(t.fwd, t.i, t.br, t.mw);
        @(negedge clk);
        chk("v_freeze",    bif.freeze,    int'(t.fz));
        chk("v_flush",     bif.flush,     int'(t.fl));
        chk("v_pipe_hold", bif.pipe_hold, int'(t.ho));
        chk("v_fwd_sel_a", bif.fwd_sel_a, t.sa);
        chk("v_fwd_sel_b", bif.fwd_sel_b, t.sb);
        chk("v_stall_cnt", bif.stall_cnt, t.sc);
        chk("v_flush_cnt", bif.flush_cnt, t.fc);
        chk("v_sat_stall", sif.stall_cnt, sat(t.sc, 3));
        chk("v_sat_flush", sif.flush_cnt, sat(t.fc, 3));
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t nop, add1, sub2, ldr4, add5, orr6, prod, cons;
        nop  = mk(0, 0, 0, 0, 0, 0, 0);
        add1 = mk(1, 1, 0, 1, 1, 2, 3);   // ADD r1, r2, r3
        sub2 = mk(1, 1, 0, 1, 2, 1, 3);   // SUB r2, r1, r3
        ldr4 = mk(1, 1, 1, 0, 4, 5, 0);   // LDR r4, [r5]
        add5 = mk(1, 1, 0, 1, 5, 4, 4);   // ADD r5, r4, r4
        orr6 = mk(1, 1, 0, 0, 6, 2, 0);   // reads r2: would stall if SUB had slipped into EXE
        prod = mk(1, 1, 0, 0, 1, 8, 0);
        cons = mk(1, 1, 0, 0, 9, 1, 0);

        // Reset state, with a hold request present to show outputs are forced low.
        rst = 1'b1;
        apply(1'b1, add5, 1'b1, 1'b1);
        #3;
        chk("rst_freeze",    bif.freeze,    0);
        chk("rst_flush",     bif.flush,     0);
        chk("rst_pipe_hold", bif.pipe_hold, 0);
        chk("rst_fwd_sel_a", bif.fwd_sel_a, 0);
        chk("rst_stall_cnt", bif.stall_cnt, 0);
        chk("rst_flush_cnt", bif.flush_cnt, 0);
        apply(1'b1, nop, 1'b0, 1'b0);
        do_reset();

        //                 fwd  ins   br mw  fz fl ho sa sb sc fc
        vecs.push_back(vv(1, add1, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // forwarding ALU chain
        vecs.push_back(vv(1, sub2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(vv(1, nop,  0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(vv(1, nop,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(vv(1, nop,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(vv(1, ldr4, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // load-use
        vecs.push_back(vv(1, add5, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(vv(1, add5, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(vv(1, nop,  0, 0, 0, 0, 0, 2, 2, 1, 0));
        vecs.push_back(vv(1, nop,  0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(vv(1, nop,  0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(vv(0, add1, 0, 0, 0, 0, 0, 0, 0, 1, 0));   // full-stall mode
        vecs.push_back(vv(0, sub2, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(vv(0, sub2, 0, 0, 1, 0, 0, 0, 0, 2, 0));
        vecs.push_back(vv(0, sub2, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(vv(0, nop,  0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(vv(0, nop,  0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(vv(0, nop,  0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(vv(0, add1, 0, 0, 0, 0, 0, 0, 0, 3, 0));   // branch beats hazard
        vecs.push_back(vv(0, sub2, 1, 0, 0, 1, 0, 0, 0, 3, 0));
        vecs.push_back(vv(0, orr6, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(vv(0, nop,  0, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(vv(0, nop,  0, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(vv(0, nop,  0, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(vv(1, ldr4, 0, 0, 0, 0, 0, 0, 0, 3, 1));   // memory wait
        vecs.push_back(vv(1, add5, 1, 1, 1, 0, 1, 0, 0, 3, 1));
        vecs.push_back(vv(1, add5, 1, 1, 1, 0, 1, 0, 0, 3, 1));
        vecs.push_back(vv(1, add5, 1, 1, 1, 0, 1, 0, 0, 3, 1));
        vecs.push_back(vv(1, add5, 1, 0, 0, 1, 0, 0, 0, 3, 1));
        vecs.push_back(vv(1, nop,  0, 0, 0, 0, 0, 0, 0, 3, 2));
        foreach (vecs[n]) run_vec(vecs[n]);

        // Saturation: five stalls in full-stall mode, then reset lands mid-stall.
        do_reset();
        cycle(0, prod, 0, 0); cycle(0, cons, 0, 0); cycle(0, cons, 0, 0); cycle(0, cons, 0, 0);
        cycle(0, prod, 0, 0); cycle(0, cons, 0, 0); cycle(0, cons, 0, 0); cycle(0, cons, 0, 0);
        cycle(0, prod, 0, 0); cycle(0, cons, 0, 0);
        apply(1'b0, cons, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_hold_at_3",  sif.stall_cnt, 3);
        chk("main_stall_5",   bif.stall_cnt, 5);
        chk("mid_stall_frz",  bif.freeze,    1);
        rst = 1'b1;
        #1;
        chk("rst_mid_freeze", bif.freeze,    0);
        chk("rst_mid_flush",  bif.flush,     0);
        chk("rst_mid_hold",   bif.pipe_hold, 0);
        chk("rst_mid_sel_a",  bif.fwd_sel_a, 0);
        chk("rst_mid_sel_b",  bif.fwd_sel_b, 0);
        chk("rst_mid_scnt",   bif.stall_cnt, 0);
        chk("rst_mid_sat",    sif.stall_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        apply(1'b0, cons, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_advance", bif.freeze, 0);
        @(posedge clk);
        model_step();
        #1;

        // Random traffic on a small register set so dependencies are frequent.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ins_t r;
            r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
            cycle($urandom_range(0, 4) != 0, r, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised pipeline control block for the 5-stage ARM core. It replaces the combinational hazard detector and the ad-hoc freeze/flush wiring at the core top level. It keeps a registered scoreboard of the instructions in EXE, MEM and WB, and from it generates stall, flush and EXE-operand forwarding selects. A runtime forwarding-enable input selects full-stall or forwarding mode, and saturating performance counters report stall and flush cycles.

## Interface
- ADDR_W, 4, register-file address width
- CNT_W, 16, width of each performance counter

- clk  in  1  core clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- fwd_en  in  1  1 = forwarding mode, 0 = full-stall mode
- id_valid  in  1  ID stage holds a real instruction
- id_src1  in  ADDR_W  Rn of the ID instruction; always compared
- id_src2  in  ADDR_W  second source (Rm, or Rd for a store)
- id_two_src  in  1  id_src2 is a real operand
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- id_dest  in  ADDR_W  destination of the ID instruction
- exe_branch_taken  in  1  branch taken, resolved by the instruction in EXE
- mem_wait  in  1  data memory not ready; the whole pipe must hold
- freeze  out  1  hold the PC and the IF/ID register
- flush  out  1  kill the IF/ID contents and insert a bubble into ID/EXE
- pipe_hold  out  1  hold every pipeline register (equal to mem_wait)
- fwd_sel_a  out  2  EXE operand A source: 0 = register file, 1 = MEM ALU result, 2 = WB value
- fwd_sel_b  out  2  EXE operand B source, same encoding as fwd_sel_a
- stall_cnt  out  CNT_W  count of hazard-stall cycles
- flush_cnt  out  CNT_W  count of flush cycles

## Operation
- Scoreboard:
  - Three entries: E0 = EXE, E1 = MEM, E2 = WB.
  - Each entry holds {valid, wb_en, mem_r_en, dest, src1, src2, two_src}.
- match(e, r) = e.valid & e.wb_en & (e.dest == r).
- Hazard in full-stall mode (fwd_en = 0):
  - hz = id_valid & (match(E0,id_src1) | match(E1,id_src1) | id_two_src & (match(E0,id_src2) | match(E1,id_src2))).
  - E2 is excluded because the register file writes through.
- Hazard in forwarding mode (fwd_en = 1):
  - hz = id_valid & E0.mem_r_en & (match(E0,id_src1) | id_two_src & match(E0,id_src2)).
  - Only a load-use dependency stalls.
- Each cycle, exactly one case applies, in this priority order:
  1. mem_wait = 1 (HOLD):
     - Scoreboard unchanged.
     - freeze = 1, flush = 0, pipe_hold = 1.
     - Counters unchanged.
     - A pending branch is taken in the first cycle after mem_wait falls.
  2. exe_branch_taken = 1 (FLUSH):
     - E0 <= bubble, E1 <= E0, E2 <= E1.
     - flush = 1, freeze = 0; hz is ignored.
     - flush_cnt += 1.
  3. hz = 1 (STALL):
     - E0 <= bubble, E1 <= E0, E2 <= E1.
     - freeze = 1.
     - stall_cnt += 1.
  4. Otherwise (ADVANCE):
     - E0 <= ID fields, with valid = id_valid; E1 <= E0, E2 <= E1.
- A bubble is an entry with all fields zero.
- Forwarding selects (combinational from the scoreboard only):
  - fwd_sel_a = 0 when fwd_en = 0 or E0.valid = 0.
  - Otherwise fwd_sel_a = 1 if match(E1,E0.src1), else 2 if match(E2,E0.src1), else 0.
  - fwd_sel_b uses E0.src2, and is additionally forced to 0 when E0.two_src = 0.
  - The MEM stage (select 1) has priority over WB (select 2).
- Counters saturate at all-ones and never wrap.
- A fwd_en change takes effect on the very next hazard evaluation; no scoreboard flush is required.

## Timing
- Reset:
  - All scoreboard entries are bubbles; stall_cnt = flush_cnt = 0.
  - While rst is high, freeze, flush, pipe_hold, fwd_sel_a and fwd_sel_b are all forced to 0.
- freeze, flush and pipe_hold are combinational from the inputs and the current scoreboard, valid in the same cycle.
- The scoreboard and counters update on the rising clk edge.
- Forwarding selects reflect E0 in the cycle that instruction is in EXE: zero added latency.
- Load-use in forwarding mode costs exactly 1 stall cycle. The consumer then forwards from WB (select 2).
- Dependency in full-stall mode:
  - Distance 1: 2 stall cycles.
  - Distance 2: 1 stall cycle.
  - Distance 3: none.
- Reset asserted mid-stall clears the scoreboard immediately; the first cycle after reset is ADVANCE.

## Test plan
- Forwarding ALU chain:
  - Stimulus: fwd_en = 1; ADD r1 issued, then SUB r2, r1, r3 in the next cycle.
  - Expect: no stall; fwd_sel_a = 1 while SUB is in EXE; stall_cnt stays 0.
- Load-use:
  - Stimulus: fwd_en = 1; LDR r4 followed by ADD r5, r4, r4 (two_src = 1).
  - Expect: freeze high for 1 cycle; in the consumer's EXE cycle fwd_sel_a = fwd_sel_b = 2; stall_cnt = 1.
- Full-stall mode:
  - Stimulus: fwd_en = 0; same ADD/SUB pair as the forwarding chain.
  - Expect: freeze high for 2 cycles; fwd_sel_a = 0 throughout; stall_cnt = 2.
- Branch beats hazard:
  - Stimulus: exe_branch_taken = 1 in the same cycle hz = 1.
  - Expect: flush = 1, freeze = 0, E0 becomes a bubble, flush_cnt = 1, stall_cnt unchanged.
- Memory wait:
  - Stimulus: mem_wait high for 3 cycles while a load-use hazard and a taken branch are pending.
  - Expect: pipe_hold = freeze = 1 for 3 cycles with the scoreboard frozen; the cycle after, flush = 1.
- Saturation and reset:
  - Stimulus: CNT_W = 2; force 5 stall cycles, then pulse rst mid-stall.
  - Expect: stall_cnt holds at 3; rst immediately clears the counter, zeroes all outputs and empties the scoreboard.
